// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: receive-side timing checker for the VGA output.
// Recovers active-pixel coordinates, measures line/frame geometry, tracks
// lock against the nominal timing and produces a per-frame 24-bit checksum.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [23:0] rgb,
  input  logic        clr_err,
  output logic        pix_valid,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        locked,
  output logic        frame_done,
  output logic [23:0] frame_sum,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [3:0]  err
);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state_q;
  logic        en_q, hs_q, vs_q, bl_q, hs_prev_q, vs_prev_q;
  logic [23:0] rgb_q;
  logic [10:0] h_cnt_q, line_len_q;
  logic [9:0]  v_cnt_q, a_cnt_q, act_q, x_q, y_q, frame_lines_q;
  logic [23:0] sum_q, frame_sum_q;
  logic [7:0]  good_q;
  logic        skip_q, bad_q, pix_valid_q, frame_done_q, locked_q;
  logic [3:0]  err_q;

  logic        h_fall, v_fall, checking, line_had_act, any_err, frame_clean;
  logic [10:0] len_meas;
  logic [9:0]  v_cnt_eff, act_eff, a_base, act_base;
  logic [23:0] sum_base;
  logic [3:0]  new_err;

  // Capture the inputs on each strobe and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      bl_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      en_q <= pix_en;
      if (pix_en) begin
        hs_prev_q <= hs_q;
        vs_prev_q <= vs_q;
        hs_q      <= hsync;
        vs_q      <= vsync;
        bl_q      <= blank_n;
        rgb_q     <= rgb;
      end
    end
  end

  // Edge decode and the measurements closed by this sample; a coincident
  // hsync fall is folded in before the vsync fall closes the frame.
  always_comb begin
    h_fall       = en_q & hs_prev_q & ~hs_q;
    v_fall       = en_q & vs_prev_q & ~vs_q;
    checking     = (state_q != SEARCH);
    len_meas     = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 11'd1;
    v_cnt_eff    = v_cnt_q;
    if (h_fall && v_cnt_q != '1) v_cnt_eff = v_cnt_q + 10'd1;
    line_had_act = h_fall && (a_cnt_q != '0);
    act_eff      = act_q;
    if (line_had_act && act_q != '1) act_eff = act_q + 10'd1;
    a_base       = h_fall ? '0 : a_cnt_q;
    act_base     = v_fall ? '0 : act_eff;
    sum_base     = v_fall ? '0 : sum_q;
    new_err[0]   = checking && h_fall && !skip_q && (len_meas != 11'(H_TOTAL));
    new_err[1]   = checking && v_fall && (v_cnt_eff != 10'(V_TOTAL));
    new_err[2]   = checking && line_had_act && (a_cnt_q != 10'(H_ACTIVE));
    new_err[3]   = checking && v_fall && (act_eff != 10'(V_ACTIVE));
    any_err      = |new_err;
    frame_clean  = !bad_q && !any_err;
  end

  // Counters, checksum, sticky errors and the lock state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      h_cnt_q       <= '0;
      line_len_q    <= '0;
      v_cnt_q       <= '0;
      frame_lines_q <= '0;
      a_cnt_q       <= '0;
      act_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sum_q         <= '0;
      frame_sum_q   <= '0;
      good_q        <= '0;
      skip_q        <= 1'b0;
      bad_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= '0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= (clr_err ? '0 : err_q) | new_err;
      if (en_q) begin
        h_cnt_q <= h_fall ? '0 : len_meas;
        if (h_fall) line_len_q <= len_meas;
        v_cnt_q <= v_fall ? '0 : v_cnt_eff;
        if (v_fall) begin
          frame_lines_q <= v_cnt_eff;
          frame_sum_q   <= sum_q;
        end
        a_cnt_q <= a_base;
        act_q   <= act_base;
        sum_q   <= sum_base;
        if (bl_q) begin
          pix_valid_q <= 1'b1;
          x_q         <= a_base;
          y_q         <= act_base;
          a_cnt_q     <= (a_base == '1) ? a_base : a_base + 10'd1;
          sum_q       <= sum_base + rgb_q;
        end
        if (h_fall) skip_q <= 1'b0;
        bad_q <= v_fall ? 1'b0 : (bad_q | any_err);
        unique case (state_q)
          SEARCH: begin
            if (v_fall) begin
              state_q <= ALIGN;
              good_q  <= '0;
              skip_q  <= 1'b1;
            end
          end
          ALIGN: begin
            if (v_fall) begin
              if (frame_clean) begin
                if (good_q + 8'd1 >= 8'(LOCK_FRAMES)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  good_q   <= '0;
                end else begin
                  good_q <= good_q + 8'd1;
                end
              end else begin
                good_q <= '0;
              end
            end else if (any_err) begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            if (v_fall) frame_done_q <= 1'b1;
            if (any_err) begin
              state_q  <= ALIGN;
              locked_q <= 1'b0;
              good_q   <= '0;
              skip_q   <= 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign frame_sum   = frame_sum_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err         = err_q;

endmodule
